// File: rtl/fadd_issue_wb.sv
// Issue/writeback controller for a fixed-latency, non-stallable FP adder pipeline.
// Latency: result enters writeback FIFO LAT edges after accept; visible on wb_* one cycle later.
// Backpressure: issue is gated by credits (in-flight + buffered < DEPTH); wb_ready stalls FIFO head.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous squash of every in-flight and buffered op
//   in_valid/in_ready   request handshake; in_a, in_b, in_sub, in_rd carry the request
//   add_a/add_b/add_sub combinational operand copies to the adder; add_result returns from it
//   wb_valid/wb_ready   writeback handshake; wb_data, wb_rd carry the FIFO head
//   busy                any op in flight or buffered
module fadd_issue_wb #(
  parameter int LAT   = 5,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_sub,
  input  logic [TAGW-1:0] in_rd,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  output logic            add_sub,
  input  logic [31:0]     add_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [TAGW-1:0] wb_rd,
  output logic            busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [TAGW-1:0] rd;
    logic [31:0]     data;
  } entry_t;

  // Tag pipeline shadowing the adder stages.
  logic [LAT-1:0]           vld_sr_q, vld_sr_d;
  logic [LAT-1:0][TAGW-1:0] tag_sr_q, tag_sr_d;

  // Writeback FIFO.
  entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;

  logic [CW:0] used;
  logic        accept, retire, push, pop;

  assign add_a   = in_a;
  assign add_b   = in_b;
  assign add_sub = in_sub;

  // Credits only count what is already committed; a retire or pop this cycle
  // frees its slot next cycle, so a retiring result can never find the FIFO full.
  assign used     = {1'b0, inflight_q} + {1'b0, count_q};
  assign in_ready = !flush && (used < DEPTH_C);

  assign accept = in_valid && in_ready;
  assign retire = vld_sr_q[LAT-1];
  assign push   = retire && !flush;
  assign pop    = wb_valid && wb_ready && !flush;

  assign wb_valid = (count_q != '0);
  assign wb_data  = mem_q[rd_ptr_q].data;
  assign wb_rd    = mem_q[rd_ptr_q].rd;
  assign busy     = (inflight_q != '0) || (count_q != '0);

  always_comb begin
    vld_sr_d   = vld_sr_q;
    tag_sr_d   = {tag_sr_q[LAT-2:0], in_rd};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    if (flush) begin
      // Results still travelling through the adder are orphaned by clearing their valid bits.
      vld_sr_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end else begin
      vld_sr_d   = {vld_sr_q[LAT-2:0], accept};
      inflight_d = inflight_q + CW'(accept) - CW'(retire);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q   <= '0;
      tag_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      mem_q      <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      tag_sr_q   <= tag_sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      if (push) mem_q[wr_ptr_q] <= '{rd: tag_sr_q[LAT-1], data: add_result};
    end
  end

endmodule

// File: tb/tb_fadd_issue_wb.sv
// Bench for fadd_issue_wb with a behavioural 5-stage adder model and a scoreboard.
// Latency: n/a.
// Backpressure: driven through wb_ready patterns and held in_valid.
module tb_fadd_issue_wb;

  localparam int LAT  = 5;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_a = '0;
  logic [31:0]     in_b = '0;
  logic            in_sub = 1'b0;
  logic [TAGW-1:0] in_rd = '0;
  logic [31:0]     add_a, add_b;
  logic            add_sub;
  logic [31:0]     add_result;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [31:0]     wb_data;
  logic [TAGW-1:0] wb_rd;
  logic            busy;

  logic [31:0] cur_exp = '0;
  logic [TAGW+31:0] exp_q[$];
  int compared = 0;
  int failed   = 0;
  int acc_cnt  = 0;

  always #5 clk = ~clk;

  fadd_issue_wb #(.LAT(LAT), .DEPTH(4), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rd(in_rd),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_result(add_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .busy(busy)
  );

  // Small-integer float table: enough for every operand used below.
  function automatic logic [31:0] i2f(input int v);
    case (v)
      0: i2f = 32'h00000000;
      1: i2f = 32'h3F800000;
      2: i2f = 32'h40000000;
      3: i2f = 32'h40400000;
      4: i2f = 32'h40800000;
      5: i2f = 32'h40A00000;
      6: i2f = 32'h40C00000;
      7: i2f = 32'h40E00000;
      8: i2f = 32'h41000000;
      default: i2f = 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int f2i(input logic [31:0] f);
    case (f)
      32'h00000000: f2i = 0;
      32'h3F800000: f2i = 1;
      32'h40000000: f2i = 2;
      32'h40400000: f2i = 3;
      32'h40800000: f2i = 4;
      32'h40A00000: f2i = 5;
      32'h40C00000: f2i = 6;
      32'h40E00000: f2i = 7;
      32'h41000000: f2i = 8;
      default:      f2i = -100;
    endcase
  endfunction

  // Adder model: LAT register stages, result valid after the LAT-th sampling edge.
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= i2f(add_sub ? f2i(add_a) - f2i(add_b) : f2i(add_a) + f2i(add_b));
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign add_result = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop/compare on writeback handshake.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({in_rd, cur_exp});
        acc_cnt++;
      end
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFFFFFF);
        end else begin
          logic [TAGW+31:0] e;
          e = exp_q.pop_front();
          chk("wb_data", wb_data, e[31:0]);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[TAGW+31:32]});
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [TAGW-1:0] rd, input logic [31:0] exp);
    in_a = a; in_b = b; in_sub = sub; in_rd = rd; cur_exp = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("issue_timeout", {27'd0, rd}, 32'hFFFFFFFF);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    int n, run, rdy_seen, base;
    bit gap;

    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 0);

    // 1) 1.0 + 2.0, latency check
    @(posedge clk); #1;
    issue(32'h3F800000, 32'h40000000, 1'b0, 5'd3, 32'h40400000);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wb_valid) break;
      n++;
    end
    chk("t1_latency", n, 6);
    @(negedge clk);
    chk("t1_busy_after", {31'd0, busy}, 0);

    // 2) 3.0 - 1.0
    @(posedge clk); #1;
    issue(32'h40400000, 32'h3F800000, 1'b1, 5'd7, 32'h40000000);
    wait_drain();

    // 3) credit limit with stalled writeback
    @(posedge clk); #1;
    wb_ready = 1'b0;
    base = acc_cnt;
    for (int r = 1; r <= 4; r++)
      issue(i2f(1), i2f(r), 1'b0, TAGW'(r), i2f(r + 1));
    in_a = i2f(1); in_b = i2f(5); in_sub = 1'b0; in_rd = 5'd5; cur_exp = i2f(6);
    in_valid = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
    end
    chk("t3_ready_held_low", rdy_seen, 0);
    chk("t3_accepted", acc_cnt - base, 4);
    chk("t3_head_rd", {27'd0, wb_rd}, 1);
    chk("t3_head_data", wb_data, i2f(2));
    chk("t3_head_valid", {31'd0, wb_valid}, 1);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    issue(i2f(1), i2f(5), 1'b0, 5'd5, i2f(6));
    issue(i2f(1), i2f(6), 1'b0, 5'd6, i2f(7));
    wait_drain();
    chk("t3_total_accepted", acc_cnt - base, 6);

    // 4) four back-to-back, no bubbles on writeback
    @(posedge clk); #1;
    issue(i2f(2), i2f(2), 1'b0, 5'd10, i2f(4));
    issue(i2f(8), i2f(3), 1'b1, 5'd11, i2f(5));
    issue(i2f(7), i2f(1), 1'b0, 5'd12, i2f(8));
    issue(i2f(4), i2f(4), 1'b1, 5'd13, i2f(0));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wb_valid) break;
    end
    run = 0; gap = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (wb_valid && !gap) run++;
      else gap = 1'b1;
      @(negedge clk);
    end
    chk("t4_consecutive", run, 4);
    wait_drain();

    // 5) flush squashes in-flight ops and a concurrent request
    @(posedge clk); #1;
    base = acc_cnt;
    issue(i2f(1), i2f(1), 1'b0, 5'd20, i2f(2));
    issue(i2f(1), i2f(2), 1'b0, 5'd21, i2f(3));
    issue(i2f(1), i2f(3), 1'b0, 5'd22, i2f(4));
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd23; cur_exp = i2f(5);
    @(negedge clk);
    chk("t5_ready_in_flush", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_ready_after", {31'd0, in_ready}, 1);
    chk("t5_busy_after", {31'd0, busy}, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wb_valid) n++;
    end
    chk("t5_no_wb", n, 0);
    chk("t5_accepted", acc_cnt - base, 3);

    // 6) asynchronous reset mid-stream
    @(posedge clk); #1;
    issue(i2f(3), i2f(3), 1'b0, 5'd14, i2f(6));
    issue(i2f(5), i2f(2), 1'b1, 5'd15, i2f(3));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_wb_valid", {31'd0, wb_valid}, 0);
    chk("t6_in_ready", {31'd0, in_ready}, 1);
    chk("t6_busy", {31'd0, busy}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(i2f(2), i2f(2), 1'b0, 5'd9, i2f(4));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
